frame_sync: RTL and testbench

- Serial PCM frame synchronizer, directly downstream of the bit synchronizer's formatted NRZ data/clock output.
- Correlates a programmable, masked sync pattern of up to 32 bits against the incoming bit stream.
- Runs a SEARCH/VERIFY/LOCK/FLYWHEEL state machine and emits a frame-boundary strobe, a lock flag and retimed data for the downstream word/frame formatter.

---
 rtl/frame_sync_if.sv | 40 ++++
 rtl/frame_sync.sv | 217 +++++++++++++++++++++
 tb/tb_frame_sync.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_if.sv
// frame_sync_if: serial bit stream in, retimed stream and sync status out.
// inv_flag exists only when FSYNC_INV_DETECT_EN is defined.
interface frame_sync_if;
    logic       bit_en;
    logic       bit_in;
    logic       restart;
    logic       bit_out;
    logic       bit_en_out;
    logic       sync_strobe;
    logic       frame_lock;
    logic [1:0] fs_state;
    logic [5:0] err_cnt;
`ifdef FSYNC_INV_DETECT_EN
    logic       inv_flag;

    modport master (
        output bit_en, bit_in, restart,
        input  bit_out, bit_en_out, sync_strobe,
        input  frame_lock, fs_state, err_cnt, inv_flag
    );

    modport slave (
        input  bit_en, bit_in, restart,
        output bit_out, bit_en_out, sync_strobe,
        output frame_lock, fs_state, err_cnt, inv_flag
    );
`else
    modport master (
        output bit_en, bit_in, restart,
        input  bit_out, bit_en_out, sync_strobe,
        input  frame_lock, fs_state, err_cnt
    );

    modport slave (
        input  bit_en, bit_in, restart,
        output bit_out, bit_en_out, sync_strobe,
        output frame_lock, fs_state, err_cnt
    );
`endif
endinterface

// File: rtl/frame_sync.sv
// frame_sync: PCM frame synchronizer, masked 32-bit correlator with SEARCH/VERIFY/LOCK/FLYWHEEL.
// Define FSYNC_INV_DETECT_EN to add inverted-polarity sync detection and inv_flag.
module frame_sync #(
    parameter int FLEN_W = 16,
    parameter int CNT_W  = 4
) (
    input  logic              ck933,
    input  logic              rs,
    frame_sync_if.slave       bus,
    input  logic [31:0]       sync_pat,
    input  logic [31:0]       sync_mask,
    input  logic [FLEN_W-1:0] frame_len,
    input  logic [5:0]        search_tol,
    input  logic [5:0]        lock_tol,
    input  logic [CNT_W-1:0]  verify_cnt,
    input  logic [CNT_W-1:0]  flywheel_cnt
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCK   = 2'd2,
        S_FLY    = 2'd3
    } state_t;

    localparam logic [FLEN_W-1:0] FMIN = FLEN_W'(33);

    state_t            state_q, state_d;
    logic [31:0]       sh_q, sh_d;
    logic [FLEN_W-1:0] bit_pos_q, bit_pos_d;
    logic [FLEN_W-1:0] flen_q;
    logic [CNT_W-1:0]  hits_q, hits_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic [5:0]        err_q, err_d;
    logic              bit_out_q, bit_out_d;
    logic              en_out_q, en_out_d;
    logic              strobe_q, strobe_d;
    logic              inv_q, inv_d;

    logic [FLEN_W-1:0] feff;
    logic [31:0]       sh_nx;
    logic [31:0]       corr;
    logic [5:0]        errs;
    logic              chk;
    logic              hit;
    logic              s_hit;
    logic              frc;
    logic [CNT_W:0]    hits_inc;
`ifdef FSYNC_INV_DETECT_EN
    logic [5:0]        errs_inv;
    logic              s_inv_hit;
`endif

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Correlator: decisions use the shift register including the current bit.
    always_comb begin
        feff     = (frame_len < FMIN) ? FMIN : frame_len;
        sh_nx    = {sh_q[30:0], bus.bit_in};
        corr     = inv_q ? ~sh_nx : sh_nx;
        errs     = popcnt((corr ^ sync_pat) & sync_mask);
        chk      = (bit_pos_q == (feff - FLEN_W'(1)));
        hit      = (errs <= lock_tol);
        s_hit    = (errs <= search_tol);
        frc      = bus.restart | (frame_len != flen_q);
        hits_inc = {1'b0, hits_q} + {{CNT_W{1'b0}}, 1'b1};
`ifdef FSYNC_INV_DETECT_EN
        errs_inv  = popcnt((~sh_nx ^ sync_pat) & sync_mask);
        s_inv_hit = (errs_inv <= search_tol);
`endif
    end

    always_ff @(posedge ck933) begin
        if (rs) begin
            state_q   <= S_SEARCH;
            sh_q      <= '0;
            bit_pos_q <= '0;
            flen_q    <= frame_len;
            hits_q    <= '0;
            miss_q    <= '0;
            err_q     <= '0;
            bit_out_q <= 1'b0;
            en_out_q  <= 1'b0;
            strobe_q  <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_pos_q <= bit_pos_d;
            flen_q    <= frame_len;
            hits_q    <= hits_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            bit_out_q <= bit_out_d;
            en_out_q  <= en_out_d;
            strobe_q  <= strobe_d;
            inv_q     <= inv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_pos_d = bit_pos_q;
        hits_d    = hits_q;
        miss_d    = miss_q;
        err_d     = err_q;
        bit_out_d = bit_out_q;
        en_out_d  = bus.bit_en;
        strobe_d  = 1'b0;
        inv_d     = inv_q;

        if (bus.bit_en) begin
            sh_d      = sh_nx;
            bit_pos_d = chk ? '0 : bit_pos_q + FLEN_W'(1);
        end

        // Restart and frame-length changes win over the bit decision.
        if (frc) begin
            state_d   = S_SEARCH;
            bit_pos_d = '0;
            hits_d    = '0;
            miss_d    = '0;
            inv_d     = 1'b0;
        end else if (bus.bit_en) begin
            unique case (state_q)
                S_SEARCH: begin
                    err_d = errs;
                    if (s_hit) begin
                        state_d   = S_VERIFY;
                        hits_d    = CNT_W'(1);
                        bit_pos_d = '0;
                        strobe_d  = 1'b1;
                    end
`ifdef FSYNC_INV_DETECT_EN
                    else if (s_inv_hit) begin
                        state_d   = S_VERIFY;
                        hits_d    = CNT_W'(1);
                        bit_pos_d = '0;
                        strobe_d  = 1'b1;
                        inv_d     = 1'b1;
                        err_d     = errs_inv;
                    end
`endif
                end
                S_VERIFY: begin
                    if (chk) begin
                        err_d = errs;
                        if (hit) begin
                            hits_d   = hits_inc[CNT_W-1:0];
                            strobe_d = 1'b1;
                            if (hits_inc >= {1'b0, verify_cnt}) begin
                                state_d = S_LOCK;
                            end
                        end else begin
                            state_d = S_SEARCH;
                            hits_d  = '0;
                            inv_d   = 1'b0;
                        end
                    end
                end
                S_LOCK: begin
                    if (chk) begin
                        err_d    = errs;
                        strobe_d = 1'b1;
                        if (!hit) begin
                            state_d = S_FLY;
                            miss_d  = CNT_W'(1);
                        end
                    end
                end
                S_FLY: begin
                    if (chk) begin
                        err_d = errs;
                        if (hit) begin
                            state_d  = S_LOCK;
                            miss_d   = '0;
                            strobe_d = 1'b1;
                        end else if (miss_q >= flywheel_cnt) begin
                            state_d = S_SEARCH;
                            miss_d  = '0;
                            hits_d  = '0;
                            inv_d   = 1'b0;
                        end else begin
                            miss_d   = miss_q + CNT_W'(1);
                            strobe_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (bus.bit_en) begin
            bit_out_d = bus.bit_in ^ inv_d;
        end
    end

    always_comb begin
        bus.bit_out     = bit_out_q;
        bus.bit_en_out  = en_out_q;
        bus.sync_strobe = strobe_q;
        bus.frame_lock  = (state_q == S_LOCK) || (state_q == S_FLY);
        bus.fs_state    = state_q;
        bus.err_cnt     = err_q;
`ifdef FSYNC_INV_DETECT_EN
        bus.inv_flag    = inv_q;
`endif
    end

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: directed frames checked every cycle against a bit-history model,
// plus hand-computed strobe positions and states.
module tb_frame_sync;
    localparam logic [31:0] PAT = 32'hFE6B2840;

    logic        ck933 = 1'b0;
    logic        rs = 1'b1;
    logic [31:0] sync_pat;
    logic [31:0] sync_mask;
    logic [15:0] frame_len;
    logic [5:0]  search_tol;
    logic [5:0]  lock_tol;
    logic [3:0]  verify_cnt;
    logic [3:0]  flywheel_cnt;

    frame_sync_if bus ();

    frame_sync #(.FLEN_W(16), .CNT_W(4)) dut (
        .ck933        (ck933),
        .rs           (rs),
        .bus          (bus),
        .sync_pat     (sync_pat),
        .sync_mask    (sync_mask),
        .frame_len    (frame_len),
        .search_tol   (search_tol),
        .lock_tol     (lock_tol),
        .verify_cnt   (verify_cnt),
        .flywheel_cnt (flywheel_cnt)
    );

    always #5 ck933 = ~ck933;

    int n_cmp = 0;
    int n_bad = 0;
    int bitn  = 0;
    bit cmp_on = 1'b0;
    int slog[$];

    // Model: history of received bits, newest at index 0.
    bit hist[$];
    int m_mode, m_hits, m_miss, m_since;
    int m_err, m_bout, m_en, m_stb, m_flen;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int merrs();
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (sync_mask[i] && (hist[i] != sync_pat[i])) n++;
        end
        return n;
    endfunction

    always @(posedge ck933) begin
        int e, feff;
        bit at_chk, frc;
        if (rs) begin
            hist.delete();
            for (int i = 0; i < 32; i++) hist.push_back(1'b0);
            m_mode = 0; m_hits = 0; m_miss = 0; m_since = 0;
            m_err = 0; m_bout = 0; m_en = 0; m_stb = 0;
            m_flen = int'(frame_len);
        end else begin
            m_en  = int'(bus.bit_en);
            m_stb = 0;
            frc   = bus.restart || (int'(frame_len) != m_flen);
            m_flen = int'(frame_len);
            feff  = (frame_len < 33) ? 33 : int'(frame_len);
            if (bus.bit_en) begin
                hist.push_front(bus.bit_in);
                void'(hist.pop_back());
                m_bout = int'(bus.bit_in);
            end
            if (frc) begin
                m_mode = 0; m_hits = 0; m_miss = 0; m_since = 0;
            end else if (bus.bit_en) begin
                e = merrs();
                m_since++;
                at_chk = (m_since == feff);
                if (at_chk) m_since = 0;
                if (m_mode == 0) begin
                    m_err = e;
                    if (e <= search_tol) begin
                        m_mode = 1; m_hits = 1; m_since = 0; m_stb = 1;
                    end
                end else if (at_chk) begin
                    m_err = e;
                    if (m_mode == 1) begin
                        if (e <= lock_tol) begin
                            m_hits++; m_stb = 1;
                            if (m_hits >= verify_cnt) m_mode = 2;
                        end else begin
                            m_mode = 0; m_hits = 0;
                        end
                    end else if (m_mode == 2) begin
                        m_stb = 1;
                        if (e > lock_tol) begin
                            m_mode = 3; m_miss = 1;
                        end
                    end else begin
                        if (e <= lock_tol) begin
                            m_mode = 2; m_miss = 0; m_stb = 1;
                        end else if (m_miss >= flywheel_cnt) begin
                            m_mode = 0; m_miss = 0; m_hits = 0;
                        end else begin
                            m_miss++; m_stb = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge ck933) begin
        if (cmp_on) begin
            check("bit_out", bus.bit_out, m_bout);
            check("bit_en_out", bus.bit_en_out, m_en);
            check("sync_strobe", bus.sync_strobe, m_stb);
            check("frame_lock", bus.frame_lock, (m_mode >= 2) ? 1 : 0);
            check("fs_state", bus.fs_state, m_mode);
            check("err_cnt", bus.err_cnt, m_err);
            if (bus.sync_strobe) slog.push_back(bitn);
        end
    end

    task automatic tick();
        @(posedge ck933);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_en = 1'b1;
        bus.bit_in = b;
        bitn++;
        tick();
        bus.bit_en  = 1'b0;
        bus.restart = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Sync word, state/err check at its last bit, then zero payload.
    task automatic fr(input logic [31:0] w, input int st,
                      input int er, input string nm);
        send_word(w);
        check(nm, bus.fs_state, st);
        if (er >= 0) check({nm, "_err"}, bus.err_cnt, er);
        send_zeros(int'(frame_len) - 32);
    endtask

    initial begin
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
        bus.restart = 1'b0;
        sync_pat = PAT;
        sync_mask = '1;
        frame_len = 16'd64;
        search_tol = 6'd0;
        lock_tol = 6'd0;
        verify_cnt = 4'd2;
        flywheel_cnt = 4'd2;

        rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp_on = 1'b1;
            bus.bit_en = i[0];
            bus.bit_in = 1'b1;
        end
        tick();
        rs = 1'b0;
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
        tick();
        check("rst_state", bus.fs_state, 0);
        check("rst_lock", bus.frame_lock, 0);
        check("rst_strobe", bus.sync_strobe, 0);
        check("rst_en_out", bus.bit_en_out, 0);
        check("rst_bit_out", bus.bit_out, 0);
        check("rst_err", bus.err_cnt, 0);

        // Clean lock: strobes at 32, 96, 160, 224.
        slog.delete();
        bitn = 0;
        fr(PAT, 1, 0, "clean_f1");
        fr(PAT, 2, 0, "clean_f2");
        check("clean_lock", bus.frame_lock, 1);
        fr(PAT, 2, 0, "clean_f3");
        fr(PAT, 2, 0, "clean_f4");
        check("clean_nstb", slog.size(), 4);
        check("clean_s0", slog[0], 32);
        check("clean_s1", slog[1], 96);
        check("clean_s2", slog[2], 160);
        check("clean_s3", slog[3], 224);
        check("model_lock", m_mode, 2);

        // Flywheel: three corrupt words, then relock and a single miss.
        fr(PAT ^ 32'h1, 3, 1, "fly_m1");
        check("fly_lock", bus.frame_lock, 1);
        fr(PAT ^ 32'h1, 3, 1, "fly_m2");
        fr(PAT ^ 32'h1, 0, 1, "fly_m3");
        check("fly_drop", bus.frame_lock, 0);
        check("fly_nstb", slog.size(), 6);
        check("fly_s5", slog[5], 352);
        fr(PAT, 1, 0, "relock_v");
        fr(PAT, 2, 0, "relock_l");
        fr(PAT ^ 32'h1, 3, 1, "single_miss");
        fr(PAT, 2, 0, "fly_recover");

        // Tolerance in SEARCH.
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        tick();
        check("restart_idle", bus.fs_state, 0);
        search_tol = 6'd2;
        fr(PAT ^ 32'h7, 0, 3, "tol3");
        fr(PAT ^ 32'h300, 1, 2, "tol2");
        fr(PAT, 2, 0, "tol_lock");
        search_tol = 6'd0;

        // Restart together with a bit while locked.
        bus.restart = 1'b1;
        send_bit(1'b1);
        check("rs_bit_state", bus.fs_state, 0);
        check("rs_bit_lock", bus.frame_lock, 0);
        check("rs_bit_out", bus.bit_out, 1);
        send_zeros(40);

        // Short frame_len acts as 33.
        frame_len = 16'd10;
        tick();
        slog.delete();
        bitn = 0;
        for (int f = 0; f < 3; f++) begin
            send_word(PAT);
            send_bit(1'b0);
        end
        check("short_nstb", slog.size(), 3);
        check("short_s1", slog[1], 65);
        check("short_s2", slog[2], 98);
        check("short_state", bus.fs_state, 2);
        check("model_short", m_mode, 2);

        // Partial mask with busy payload; model-only.
        frame_len = 16'd64;
        sync_mask = 32'h0000_FFFF;
        lock_tol = 6'd1;
        for (int f = 0; f < 4; f++) begin
            send_word(PAT);
            send_word(32'h1234_5678);
        end
        sync_mask = '1;
        lock_tol = 6'd0;
        send_zeros(8);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
